addsub_share_ctrl: RTL and testbench

- Round-robin controller that shares one add/subtract datapath between N requesters.
- Each requester supplies two WIDTH-bit operands and an op bit.
- The controller arbitrates, captures the operands, runs the add or subtract, and returns a tagged WIDTH+1-bit result over a valid/ready handshake.
- Sits between client blocks and the shared arithmetic unit, so a single adder/subtractor serves all clients.

---
 rtl/addsub_share_ctrl.sv | 160 ++++++++++++++++
 tb/tb_addsub_share_ctrl.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/addsub_share_ctrl.sv
// Round-robin controller sharing one add/subtract datapath between N_REQ requesters.
// Optional per-op completion counters are built when ADDSUB_SHARE_STATS_EN is defined.
module addsub_share_ctrl #(
    parameter int N_REQ = 2,
    parameter int WIDTH = 7,
    parameter int ID_W  = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req_valid,
    output logic [N_REQ-1:0]       req_ready,
    input  logic [N_REQ*WIDTH-1:0] req_a,
    input  logic [N_REQ*WIDTH-1:0] req_b,
    input  logic [N_REQ-1:0]       req_op,
    output logic                   resp_valid,
    input  logic                   resp_ready,
    output logic [WIDTH:0]         resp_y,
    output logic [ID_W-1:0]        resp_id,
    output logic                   resp_op
`ifdef ADDSUB_SHARE_STATS_EN
    ,
    output logic [15:0]            add_cnt,
    output logic [15:0]            sub_cnt
`endif
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    localparam logic [ID_W:0] N_REQ_W = (ID_W+1)'(N_REQ);

    state_t            state;
    logic [ID_W-1:0]   rr_ptr;
    logic [N_REQ-1:0]  rotated;
    logic              grant_vld;
    logic [ID_W-1:0]   grant_idx;
    logic [ID_W:0]     scan_sum;
    logic [WIDTH-1:0]  sel_a;
    logic [WIDTH-1:0]  sel_b;
    logic              sel_op;
    logic [WIDTH-1:0]  cap_a;
    logic [WIDTH-1:0]  cap_b;
    logic              cap_op;
    logic [ID_W-1:0]   cap_id;
    logic [ID_W:0]     rr_sum;
    logic [ID_W-1:0]   rr_next;
    logic [WIDTH:0]    exec_y;
    logic              resp_fire;

    // Rotate the valids so bit 0 is rr_ptr; the lowest set bit wins, then map back.
    always_comb begin
        rotated   = N_REQ'({req_valid, req_valid} >> rr_ptr);
        grant_vld = 1'b0;
        scan_sum  = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (rotated[k]) begin
                grant_vld = 1'b1;
                scan_sum  = {1'b0, rr_ptr} + (ID_W+1)'(k);
            end
        end
        if (scan_sum >= N_REQ_W) begin
            scan_sum = scan_sum - N_REQ_W;
        end
        grant_idx = scan_sum[ID_W-1:0];
    end

    always_comb begin
        req_ready = '0;
        if (state == IDLE && grant_vld) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    always_comb begin
        sel_a  = '0;
        sel_b  = '0;
        sel_op = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant_idx == ID_W'(i)) begin
                sel_a  = req_a[i*WIDTH +: WIDTH];
                sel_b  = req_b[i*WIDTH +: WIDTH];
                sel_op = req_op[i];
            end
        end
    end

    assign rr_sum    = {1'b0, cap_id} + (ID_W+1)'(1);
    assign rr_next   = (rr_sum >= N_REQ_W) ? '0 : rr_sum[ID_W-1:0];
    // Zero-extended operands: add cannot overflow, subtract wraps modulo 2**(WIDTH+1).
    assign exec_y    = cap_op ? ({1'b0, cap_a} - {1'b0, cap_b})
                              : ({1'b0, cap_a} + {1'b0, cap_b});
    assign resp_fire = resp_valid & resp_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            rr_ptr     <= '0;
            resp_valid <= 1'b0;
            resp_y     <= '0;
            resp_id    <= '0;
            resp_op    <= 1'b0;
            cap_a      <= '0;
            cap_b      <= '0;
            cap_op     <= 1'b0;
            cap_id     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_vld) begin
                        cap_a  <= sel_a;
                        cap_b  <= sel_b;
                        cap_op <= sel_op;
                        cap_id <= grant_idx;
                        state  <= EXEC;
                    end
                end
                EXEC: begin
                    resp_y     <= exec_y;
                    resp_id    <= cap_id;
                    resp_op    <= cap_op;
                    resp_valid <= 1'b1;
                    state      <= RESP;
                end
                RESP: begin
                    if (resp_fire) begin
                        resp_valid <= 1'b0;
                        rr_ptr     <= rr_next;
                        state      <= IDLE;
                    end
                end
                default: begin
                    resp_valid <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end

`ifdef ADDSUB_SHARE_STATS_EN
    // Completed handshakes per op, saturating so a long run never wraps back to small counts.
    always_ff @(posedge clk) begin
        if (rst) begin
            add_cnt <= '0;
            sub_cnt <= '0;
        end else if (resp_fire) begin
            if (resp_op) begin
                if (sub_cnt != 16'hFFFF) begin
                    sub_cnt <= sub_cnt + 16'd1;
                end
            end else begin
                if (add_cnt != 16'hFFFF) begin
                    add_cnt <= add_cnt + 16'd1;
                end
            end
        end
    end
`else
    // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_addsub_share_ctrl.sv
// Self-checking bench for addsub_share_ctrl: vector table, scoreboard and corner-case sequences.
// Stats checks are compiled in when ADDSUB_SHARE_STATS_EN is defined.
module tb_addsub_share_ctrl;

    localparam int N_REQ = 2;
    localparam int WIDTH = 7;
    localparam int ID_W  = 1;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [N_REQ-1:0]       req_valid;
    logic [N_REQ-1:0]       req_ready;
    logic [N_REQ*WIDTH-1:0] req_a;
    logic [N_REQ*WIDTH-1:0] req_b;
    logic [N_REQ-1:0]       req_op;
    logic                   resp_valid;
    logic                   resp_ready;
    logic [WIDTH:0]         resp_y;
    logic [ID_W-1:0]        resp_id;
    logic                   resp_op;
`ifdef ADDSUB_SHARE_STATS_EN
    logic [15:0]            add_cnt;
    logic [15:0]            sub_cnt;
`endif

    typedef struct {
        logic [ID_W-1:0] id;
        logic [WIDTH:0]  y;
        logic            op;
    } exp_t;

    typedef struct {
        int              idx;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic            op;
        logic [WIDTH:0]  y;
    } vec_t;

    exp_t sb[$];
    exp_t mon_exp;
    vec_t vecs[9];
    int   n_compared   = 0;
    int   n_mismatched = 0;

    addsub_share_ctrl #(.N_REQ(N_REQ), .WIDTH(WIDTH), .ID_W(ID_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_op     (req_op),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_y     (resp_y),
        .resp_id    (resp_id),
        .resp_op    (resp_op)
`ifdef ADDSUB_SHARE_STATS_EN
        ,
        .add_cnt    (add_cnt),
        .sub_cnt    (sub_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic failNow(input string name);
        n_compared++;
        n_mismatched++;
        $display("[TB] FAIL %s: got timeout, required event", name);
    endtask

    task automatic applyStimulus(input int idx, input logic [WIDTH-1:0] a,
                                 input logic [WIDTH-1:0] b, input logic op);
        req_a[idx*WIDTH +: WIDTH] = a;
        req_b[idx*WIDTH +: WIDTH] = b;
        req_op[idx]               = op;
        req_valid[idx]            = 1'b1;
    endtask

    // Called at posedge+1 right after driving; returns at posedge+1 just after the accept edge.
    task automatic waitAccept(input logic [N_REQ-1:0] exp_ready, input string name);
        int cyc = 0;
        #1;
        while (req_ready == '0 && cyc < 20) begin
            @(posedge clk);
            #2;
            cyc++;
        end
        if (req_ready == '0) failNow(name);
        else checkOutput(name, 32'(req_ready), 32'(exp_ready));
        @(posedge clk);
        #1;
    endtask

    // Returns at posedge+1 just after the handshake edge of the last queued response.
    task automatic waitDrain(input string name);
        int cyc = 0;
        while (sb.size() != 0 && cyc < 30) begin
            @(posedge clk);
            cyc++;
        end
        #1;
        if (sb.size() != 0) begin
            failNow(name);
            sb.delete();
        end
    endtask

    task automatic pushExp(input int id, input logic [WIDTH:0] y, input logic op);
        exp_t e;
        e.id = ID_W'(id);
        e.y  = y;
        e.op = op;
        sb.push_back(e);
    endtask

    task automatic runVector(input int v);
        applyStimulus(vecs[v].idx, vecs[v].a, vecs[v].b, vecs[v].op);
        waitAccept(N_REQ'(1) << vecs[v].idx, $sformatf("vec%0d_ready", v));
        pushExp(vecs[v].idx, vecs[v].y, vecs[v].op);
        req_valid = '0;
        waitDrain($sformatf("vec%0d_drain", v));
    endtask

    // Every handshake retires the oldest expected response.
    always @(negedge clk) begin
        if (rst !== 1'b1 && resp_valid === 1'b1 && resp_ready === 1'b1) begin
            if (sb.size() == 0) begin
                n_compared++;
                n_mismatched++;
                $display("[TB] FAIL resp_unexpected: got id=%0d y=%0d, required no response",
                         resp_id, resp_y);
            end else begin
                mon_exp = sb.pop_front();
                checkOutput("resp_y",  32'(resp_y),  32'(mon_exp.y));
                checkOutput("resp_id", 32'(resp_id), 32'(mon_exp.id));
                checkOutput("resp_op", 32'(resp_op), 32'(mon_exp.op));
            end
        end
    end

    initial begin
        int n_acc;
        int cyc;
        int last_acc;
        logic [N_REQ-1:0] rr_seq [4];

        vecs[0] = '{0, 7'd127, 7'd127, 1'b0, 8'd254};
        vecs[1] = '{1, 7'd5,   7'd10,  1'b1, 8'd251};
        vecs[2] = '{0, 7'd0,   7'd0,   1'b1, 8'd0};
        vecs[3] = '{1, 7'd0,   7'd1,   1'b1, 8'd255};
        vecs[4] = '{0, 7'd127, 7'd0,   1'b1, 8'd127};
        vecs[5] = '{1, 7'd64,  7'd64,  1'b0, 8'd128};
        vecs[6] = '{0, 7'd3,   7'd3,   1'b1, 8'd0};
        vecs[7] = '{1, 7'd127, 7'd127, 1'b1, 8'd0};
        vecs[8] = '{0, 7'd10,  7'd20,  1'b0, 8'd30};
        rr_seq  = '{2'b01, 2'b10, 2'b01, 2'b10};

        rst        = 1'b1;
        req_valid  = '0;
        req_a      = '0;
        req_b      = '0;
        req_op     = '0;
        resp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        $display("[TB] reset then idle");
        for (int i = 0; i < 10; i++) begin
            checkOutput("idle_resp_valid", 32'(resp_valid), 32'd0);
            checkOutput("idle_req_ready",  32'(req_ready),  32'd0);
            checkOutput("idle_resp_y",     32'(resp_y),     32'd0);
            @(posedge clk);
            #1;
        end
        checkOutput("idle_resp_id", 32'(resp_id), 32'd0);
        checkOutput("idle_resp_op", 32'(resp_op), 32'd0);

        $display("[TB] single add");
        applyStimulus(0, 7'd100, 7'd27, 1'b0);
        waitAccept(2'b01, "add_ready");
        pushExp(0, 8'd127, 1'b0);
        req_valid = '0;
        checkOutput("add_ready_pulse", 32'(req_ready), 32'd0);
        checkOutput("add_exec_valid", 32'(resp_valid), 32'd0);
        @(posedge clk);
        #1;
        checkOutput("add_latency_valid", 32'(resp_valid), 32'd1);
        @(posedge clk);
        #1;
        checkOutput("add_valid_width", 32'(resp_valid), 32'd0);
        checkOutput("add_drained", 32'(sb.size()), 32'd0);

        $display("[TB] subtract wrap with backpressure");
        resp_ready = 1'b0;
        applyStimulus(1, 7'd5, 7'd10, 1'b1);
        waitAccept(2'b10, "sub_ready");
        pushExp(1, 8'd251, 1'b1);
        req_valid = '0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 5; i++) begin
            checkOutput("stall_valid", 32'(resp_valid), 32'd1);
            checkOutput("stall_y",     32'(resp_y),     32'd251);
            checkOutput("stall_id",    32'(resp_id),    32'd1);
            checkOutput("stall_op",    32'(resp_op),    32'd1);
            @(posedge clk);
            #1;
        end
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("sub_release_valid", 32'(resp_valid), 32'd0);
        checkOutput("sub_drained", 32'(sb.size()), 32'd0);

        $display("[TB] round robin");
        for (int i = 0; i < 2; i++) begin
            pushExp(0, 8'd2, 1'b0);
            pushExp(1, 8'd6, 1'b1);
        end
        applyStimulus(0, 7'd1, 7'd1, 1'b0);
        applyStimulus(1, 7'd9, 7'd3, 1'b1);
        #1;
        n_acc    = 0;
        cyc      = 0;
        last_acc = 0;
        while (n_acc < 4 && cyc < 40) begin
            if (req_ready != '0) begin
                checkOutput($sformatf("rr_grant%0d", n_acc), 32'(req_ready), 32'(rr_seq[n_acc]));
                if (n_acc > 0) checkOutput("rr_spacing", 32'(cyc - last_acc), 32'd3);
                last_acc = cyc;
                n_acc++;
            end
            if (n_acc < 4) begin
                @(posedge clk);
                #2;
                cyc++;
            end
        end
        if (n_acc < 4) failNow("rr_accepts");
        @(posedge clk);
        #1;
        req_valid = '0;
        waitDrain("rr_drain");

        $display("[TB] vector table");
        for (int v = 0; v < 8; v++) begin
            runVector(v);
        end

        $display("[TB] reset mid-operation");
        applyStimulus(0, 7'd50, 7'd50, 1'b0);
        waitAccept(2'b01, "rst_ready");
        rst       = 1'b1;
        req_valid = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            checkOutput("rst_no_resp",  32'(resp_valid), 32'd0);
            checkOutput("rst_no_ready", 32'(req_ready),  32'd0);
            @(posedge clk);
            #1;
        end
        applyStimulus(1, 7'd20, 7'd22, 1'b0);
        waitAccept(2'b10, "post_rst_ready");
        pushExp(1, 8'd42, 1'b0);
        req_valid = '0;
        waitDrain("post_rst_drain");

`ifdef ADDSUB_SHARE_STATS_EN
        $display("[TB] stats counters");
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput("stats_clear_add", 32'(add_cnt), 32'd0);
        runVector(0);
        runVector(5);
        runVector(8);
        runVector(1);
        runVector(2);
        checkOutput("stats_add_cnt", 32'(add_cnt), 32'd3);
        checkOutput("stats_sub_cnt", 32'(sub_cnt), 32'd2);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput("stats_rst_add", 32'(add_cnt), 32'd0);
        checkOutput("stats_rst_sub", 32'(sub_cnt), 32'd0);
`endif

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
